// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, flag layout,
// FSM states and the per-opcode architectural flag write mask.
package alu_arbiter_pkg;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_XOR    = 3'b010;
  localparam logic [2:0] OP_RED    = 3'b011;
  localparam logic [2:0] OP_SLL    = 3'b100;
  localparam logic [2:0] OP_SRA    = 3'b101;
  localparam logic [2:0] OP_ROR    = 3'b110;
  localparam logic [2:0] OP_PADSUB = 3'b111;

  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 0;

  localparam logic [2:0] FLAG_RST = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic [2:0] flag_mask(input logic [2:0] op);
    logic [2:0] m;
    m = '0;
    case (op)
      OP_ADD, OP_SUB:                 m = (3'b001 << FLAG_Z) | (3'b001 << FLAG_V) | (3'b001 << FLAG_N);
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'b001 << FLAG_Z;
      default:                        m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Single-cycle 16-bit ALU. V reports signed overflow or unsigned carry/borrow
// on ADD/SUB; error mirrors V there and flags any lane borrow on PADSUB.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] alu_out,
  output logic [2:0]  flags,
  output logic        error
);

  logic [16:0] sum;
  logic [31:0] rot;
  logic [8:0]  hi;
  logic [8:0]  lo;
  logic        v;
  logic [3:0]  sh;

  assign sh = b[3:0];

  always_comb begin
    alu_out = '0;
    v       = 1'b0;
    error   = 1'b0;
    sum     = '0;
    rot     = '0;
    hi      = '0;
    lo      = '0;
    case (op)
      OP_ADD: begin
        sum     = {1'b0, a} + {1'b0, b};
        alu_out = sum[15:0];
        v       = sum[16] | ((a[15] == b[15]) & (alu_out[15] != a[15]));
        error   = v;
      end
      OP_SUB: begin
        sum     = {1'b0, a} - {1'b0, b};
        alu_out = sum[15:0];
        v       = sum[16] | ((a[15] != b[15]) & (alu_out[15] != a[15]));
        error   = v;
      end
      OP_XOR: alu_out = a ^ b;
      OP_RED: alu_out = {15'd0, ^a};
      OP_SLL: alu_out = a << sh;
      OP_SRA: alu_out = $unsigned($signed(a) >>> sh);
      OP_ROR: begin
        rot     = {a, a} >> sh;
        alu_out = rot[15:0];
      end
      OP_PADSUB: begin
        hi      = {1'b0, a[15:8]} - {1'b0, b[15:8]};
        lo      = {1'b0, a[7:0]} - {1'b0, b[7:0]};
        alu_out = {hi[7:0], lo[7:0]};
        error   = hi[8] | lo[8];
      end
      default: alu_out = '0;
    endcase
    flags = '0;
    flags[FLAG_Z] = (alu_out == '0);
    flags[FLAG_V] = v;
    flags[FLAG_N] = alu_out[15];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters with registered
// operands, a held response, and a per-requester architectural flag register.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic [2:0]  rsp_flags,
  output logic        rsp_error,
  output logic [2:0]  flags0,
  output logic [2:0]  flags1
);

  state_t      state, state_nxt;
  logic        last_grant;
  logic [2:0]  op_q;
  logic [15:0] a_q, b_q;
  logic        id_q;
  logic        grant0, grant1, accept, rsp_done;
  logic [15:0] alu_out;
  logic [2:0]  alu_flags;
  logic        alu_error;
  logic [2:0]  wmask;

  alu_arbiter_alu u_alu (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .alu_out (alu_out),
    .flags   (alu_flags),
    .error   (alu_error)
  );

  // last_grant names the previous winner; on a tie the other side wins.
  assign grant0 = req0_valid & (~req1_valid | last_grant);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant);
  assign wmask  = flag_mask(op_q);

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      S_IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        accept     = grant0 | grant1;
        if (accept) state_nxt = S_EXEC;
      end
      S_EXEC: state_nxt = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_flags  <= '0;
      rsp_error  <= 1'b0;
      flags0     <= FLAG_RST;
      flags1     <= FLAG_RST;
    end else begin
      if (accept) begin
        op_q       <= grant1 ? req1_op : req0_op;
        a_q        <= grant1 ? req1_a  : req0_a;
        b_q        <= grant1 ? req1_b  : req0_b;
        id_q       <= grant1;
        last_grant <= grant1;
      end
      if (state == S_EXEC) begin
        rsp_id    <= id_q;
        rsp_data  <= alu_out;
        rsp_flags <= alu_flags;
        rsp_error <= alu_error;
      end
      // op_q is only reloaded on accept, so it still names the responding op.
      if (rsp_done) begin
        if (rsp_id) flags1 <= (flags1 & ~wmask) | (rsp_flags & wmask);
        else        flags0 <= (flags0 & ~wmask) | (rsp_flags & wmask);
      end
    end
  end

endmodule
